mips_multicycle_controller: RTL and testbench
=============================================

Name: mips_multicycle_controller

Overview:
Control unit for the multicycle MIPS datapath under `top`. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath mux select, write enable and ALU control from the instruction opcode/funct and the ALU zero flag. It supports lw, sw, R-type (add, sub, and, or, slt), beq, addi and j, and flags illegal opcodes.

Parameters:
STATE_W, 4, width of state register and of state_dbg port (min 4)
TRAP_ILLEGAL, 1, 1 = pulse illegal_op on unknown opcode in DECODE; 0 = tie illegal_op low

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
memwrite  out  1  data memory write enable
irwrite  out  1  instruction register load
regdst  out  1  write register select: 0 = rt, 1 = rd
memtoreg  out  1  writeback select: 0 = ALUOut, 1 = memory data
regwrite  out  1  register file write enable
alusrca  out  1  ALU A select: 0 = PC, 1 = rs data
alusrcb  out  2  ALU B select: 00 = rt data, 01 = const 4, 10 = signimm, 11 = signimm<<2
pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
alucontrol  out  3  ALU operation
pcen  out  1  PC register enable
illegal_op  out  1  one-cycle flag: unknown opcode decoded
state_dbg  out  STATE_W  current state encoding

Behaviour:
- Moore FSM with registered state. Outputs are combinational from state only, except: pcen = pcwrite | (branch & zero); alucontrol also depends on funct.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by op:
    - 100011/101011 -> MEMADR
    - 000000 -> EXECUTE
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - else -> FETCH
  - MEMADR -> MEMRD if op = lw, else MEMWR.
  - MEMRD -> MEMWB; EXECUTE -> ALUWB; ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
  - Encodings 12..(2^STATE_W - 1) -> FETCH next cycle, all enables 0.
- Asserted signals per state (unlisted signals 0):
  - FETCH: irwrite, pcwrite, alusrcb=01, aluop=00
  - DECODE: alusrcb=11, aluop=00
  - MEMADR: alusrca, alusrcb=10, aluop=00
  - MEMRD: iord
  - MEMWB: memtoreg, regwrite
  - MEMWR: iord, memwrite
  - EXECUTE: alusrca, aluop=10
  - ALUWB: regdst, regwrite
  - BRANCH: alusrca, aluop=01, pcsrc=01, branch
  - ADDIEX: alusrca, alusrcb=10, aluop=00
  - ADDIWB: regwrite
  - JUMP: pcsrc=10, pcwrite
- alucontrol decode:
  - aluop 00 -> 010 (add); aluop 01 -> 110 (sub).
  - aluop 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, other -> 010.
- Latency in cycles, FETCH through last state inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- illegal_op: high exactly during the DECODE cycle of an unknown opcode (TRAP_ILLEGAL=1), else 0.
- Reset:
  - reset low at a clock edge loads FETCH regardless of current state, including mid-instruction (e.g., MEMWR).
  - While reset is low, irwrite, pcen, regwrite, memwrite and illegal_op are forced 0. Other outputs show FETCH values.
  - First FETCH with enables active is the first cycle after the edge that samples reset high.
- zero is sampled only in BRANCH. It is ignored in all other states, with no effect on pcen there.

Test Plan:
- Hold reset low 3 cycles with op=100011 -> state_dbg=0 and memwrite=regwrite=irwrite=pcen=0 throughout. Release -> next cycle irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- lw (op=100011) -> state_dbg 0,1,2,3,4 on consecutive cycles; iord=1 in cycle 4; regwrite=1, memtoreg=1, regdst=0 in cycle 5; state_dbg=0 in cycle 6.
- sw (op=101011) -> states 0,1,2,5; memwrite=1 and iord=1 only in state 5; regwrite never 1.
- R-type op=000000 with funct 100000/100010/100100/100101/101010 -> alucontrol in EXECUTE = 010/110/000/001/111; ALUWB gives regwrite=1, regdst=1. funct=000111 -> alucontrol=010.
- beq op=000100 -> BRANCH state: zero=1 gives pcen=1, pcsrc=01, alucontrol=110; zero=0 gives pcen=0. j op=000010 -> JUMP state: pcen=1, pcsrc=10.
- op=111111 -> illegal_op=1 for the single DECODE cycle, then state_dbg=0. Pull reset low during MEMWR of a sw -> memwrite=0 that cycle, state_dbg=0 after the edge.

Source files
------------

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives all datapath selects, enables and ALU control.
module mips_multicycle_controller #(
  parameter int STATE_W      = 4,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               pcen,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    EXECUTE = STATE_W'(6),
    ALUWB   = STATE_W'(7),
    BRANCH  = STATE_W'(8),
    ADDIEX  = STATE_W'(9),
    ADDIWB  = STATE_W'(10),
    JUMP    = STATE_W'(11)
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t     state, state_nxt, cur;
  logic       rst_hold, run;
  logic       irwrite_s, regwrite_s, memwrite_s, pcwrite, branch, known_op;
  logic [1:0] aluop;

  // rst_hold keeps the first post-reset cycle in an inert FETCH, so the first
  // enabled FETCH follows the edge that samples reset high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= FETCH;
      rst_hold <= 1'b1;
    end else begin
      state    <= rst_hold ? FETCH : state_nxt;
      rst_hold <= 1'b0;
    end
  end

  assign run = reset & ~rst_hold;
  assign cur = run ? state : FETCH;

  always_comb begin
    known_op  = 1'b1;
    state_nxt = FETCH;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYP:      state_nxt = EXECUTE;
          OP_BEQ:       state_nxt = BRANCH;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JUMP;
          default: begin
            state_nxt = FETCH;
            known_op  = 1'b0;
          end
        endcase
      end
      MEMADR:  state_nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_nxt = MEMWB;
      EXECUTE: state_nxt = ALUWB;
      ADDIEX:  state_nxt = ADDIWB;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    case (cur)
      FETCH: begin
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
        alusrcb   = 2'b01;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:  regwrite_s = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  assign irwrite    = irwrite_s & run;
  assign regwrite   = regwrite_s & run;
  assign memwrite   = memwrite_s & run;
  assign pcen       = (pcwrite | (branch & zero)) & run;
  assign illegal_op = TRAP_ILLEGAL & run & (cur == DECODE) & ~known_op;
  assign state_dbg  = state;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Scoreboard bench: directed instruction sequences push expected control words,
// a negedge monitor pops and compares them against the controller outputs.
module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'b100011;
  logic [5:0] funct = 6'b000000;
  logic       zero = 1'b0;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       pcen, illegal_op;
  logic [3:0] state_dbg;

  typedef struct packed {
    logic [3:0] st;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       pcen;
    logic       illegal;
  } ctrl_t;

  ctrl_t exq[$];
  int    applied = 0;
  int    miscompares = 0;
  bit    stim_done = 1'b0;

  mips_multicycle_controller #(.STATE_W(4), .TRAP_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .pcen(pcen),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Hand-written per-state control words; caller patches funct/zero/illegal bits.
  function automatic ctrl_t fv(input logic [3:0] s);
    ctrl_t e;
    e = '0;
    e.st = s;
    e.alucontrol = 3'b010;
    case (s)
      4'd0:  begin e.irwrite = 1'b1; e.alusrcb = 2'b01; e.pcen = 1'b1; end
      4'd1:  e.alusrcb = 2'b11;
      4'd2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      4'd3:  e.iord = 1'b1;
      4'd4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      4'd5:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
      4'd6:  e.alusrca = 1'b1;
      4'd7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      4'd8:  begin e.alusrca = 1'b1; e.pcsrc = 2'b01; e.alucontrol = 3'b110; end
      4'd9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      4'd10: e.regwrite = 1'b1;
      4'd11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  // FETCH selects with every enable held off, while reset is in effect.
  function automatic ctrl_t rst_exp(input logic [3:0] s);
    ctrl_t e;
    e = fv(4'd0);
    e.irwrite = 1'b0;
    e.pcen = 1'b0;
    e.st = s;
    return e;
  endfunction

  task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input ctrl_t e);
    @(posedge clk);
    #1;
    reset = r;
    op = o;
    funct = f;
    zero = z;
    exq.push_back(e);
  endtask

  task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic [19:0] seq, input int n,
                       input logic [2:0] exec_alu, input logic ill);
    ctrl_t      e;
    logic [3:0] s;
    for (int i = 0; i < n; i++) begin
      s = seq[4*i +: 4];
      e = fv(s);
      if (s == 4'd6) e.alucontrol = exec_alu;
      if (s == 4'd8) e.pcen = z;
      if (s == 4'd1) e.illegal = ill;
      step(1'b1, o, f, z, e);
    end
  endtask

  localparam logic [19:0] SEQ_LW   = {4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
  localparam logic [19:0] SEQ_SW   = {4'd0, 4'd5, 4'd2, 4'd1, 4'd0};
  localparam logic [19:0] SEQ_R    = {4'd0, 4'd7, 4'd6, 4'd1, 4'd0};
  localparam logic [19:0] SEQ_ADDI = {4'd0, 4'd10, 4'd9, 4'd1, 4'd0};
  localparam logic [19:0] SEQ_BEQ  = {4'd0, 4'd0, 4'd8, 4'd1, 4'd0};
  localparam logic [19:0] SEQ_J    = {4'd0, 4'd0, 4'd11, 4'd1, 4'd0};
  localparam logic [19:0] SEQ_ILL  = {4'd0, 4'd0, 4'd0, 4'd1, 4'd0};

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 6'b100011, 6'd0, 1'b0, rst_exp(4'd0));
    step(1'b1, 6'b100011, 6'd0, 1'b0, rst_exp(4'd0));
    instr(6'b100011, 6'd0, 1'b1, SEQ_LW, 5, 3'b010, 1'b0);
    instr(6'b101011, 6'd0, 1'b1, SEQ_SW, 4, 3'b010, 1'b0);
    instr(6'b000000, 6'b100000, 1'b0, SEQ_R, 4, 3'b010, 1'b0);
    instr(6'b000000, 6'b100010, 1'b1, SEQ_R, 4, 3'b110, 1'b0);
    instr(6'b000000, 6'b100100, 1'b0, SEQ_R, 4, 3'b000, 1'b0);
    instr(6'b000000, 6'b100101, 1'b0, SEQ_R, 4, 3'b001, 1'b0);
    instr(6'b000000, 6'b101010, 1'b0, SEQ_R, 4, 3'b111, 1'b0);
    instr(6'b000000, 6'b000111, 1'b0, SEQ_R, 4, 3'b010, 1'b0);
    instr(6'b001000, 6'd0, 1'b1, SEQ_ADDI, 4, 3'b010, 1'b0);
    instr(6'b000100, 6'd0, 1'b1, SEQ_BEQ, 3, 3'b010, 1'b0);
    instr(6'b000100, 6'd0, 1'b0, SEQ_BEQ, 3, 3'b010, 1'b0);
    instr(6'b000010, 6'd0, 1'b1, SEQ_J, 3, 3'b010, 1'b0);
    instr(6'b111111, 6'd0, 1'b0, SEQ_ILL, 2, 3'b010, 1'b1);
    // sw interrupted by reset while in MEMWR
    instr(6'b101011, 6'd0, 1'b0, SEQ_SW, 3, 3'b010, 1'b0);
    step(1'b0, 6'b101011, 6'd0, 1'b0, rst_exp(4'd5));
    step(1'b1, 6'b101011, 6'd0, 1'b0, rst_exp(4'd0));
    instr(6'b000010, 6'd0, 1'b0, SEQ_J, 3, 3'b010, 1'b0);
    instr(6'b100011, 6'd0, 1'b0, SEQ_LW, 2, 3'b010, 1'b0);
    repeat (2) @(posedge clk);
    stim_done = 1'b1;
  end

  initial begin : monitor
    ctrl_t got, want;
    forever begin
      @(negedge clk);
      if (exq.size() > 0) begin
        want = exq.pop_front();
        got = '{st: state_dbg, iord: iord, memwrite: memwrite, irwrite: irwrite,
                regdst: regdst, memtoreg: memtoreg, regwrite: regwrite,
                alusrca: alusrca, alusrcb: alusrcb, pcsrc: pcsrc,
                alucontrol: alucontrol, pcen: pcen, illegal: illegal_op};
        applied++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL vec%0d ctrl: got st=%0d word=%h, expected st=%0d word=%h",
                   applied, got.st, got, want.st, want);
        end
      end
    end
  end

  initial begin
    fork
      wait (stim_done);
      #100000;
    join_any
    disable fork;
    if (!stim_done || exq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected words left unchecked, done=%0d", exq.size(), stim_done);
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
